// File: rtl/sisc_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// sisc_fetch_queue_if
// Bundles the instruction-memory request/response bus, the control-FSM
// consume/redirect inputs and the queue-head outputs of sisc_fetch_queue.
//   master : the fetch queue itself (drives im_req/im_addr and the head view)
//   slave  : the environment (instruction memory + control FSM)
// Signals:
//   im_req/im_addr        read request, one word per asserted cycle
//   im_valid/im_rdata     response, one cycle after each request, in order
//   ir_load               consume the head entry
//   br_taken/br_target    redirect: flush and refetch from br_target
//   iq_valid/ir_out/opcode/mm/head_pc  head entry view (zero when empty)
//   halted                HLT fetched, prefetch stopped
// -----------------------------------------------------------------------------
interface sisc_fetch_queue_if #(
  parameter int AW = 16
);
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_valid;
  logic [31:0]   im_rdata;
  logic          ir_load;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          iq_valid;
  logic [31:0]   ir_out;
  logic [3:0]    opcode;
  logic [3:0]    mm;
  logic [AW-1:0] head_pc;
  logic          halted;

  modport master (
    output im_req, im_addr, iq_valid, ir_out, opcode, mm, head_pc, halted,
    input  im_valid, im_rdata, ir_load, br_taken, br_target
  );

  modport slave (
    input  im_req, im_addr, iq_valid, ir_out, opcode, mm, head_pc, halted,
    output im_valid, im_rdata, ir_load, br_taken, br_target
  );
endinterface

// File: rtl/sisc_fetch_queue.sv
// -----------------------------------------------------------------------------
// sisc_fetch_queue
// Instruction prefetch queue in front of the SISC control FSM. Issues
// sequential word reads, buffers returned words with their fetch address in a
// DEPTH-entry FIFO and presents the head entry. Flushes on br_taken, discards
// stale responses and stops prefetching after a HLT (opcode 4'hF) is fetched.
// Ports:
//   clk    system clock, rising edge
//   rst_f  synchronous active-high reset
//   bus    sisc_fetch_queue_if.master (memory bus, FSM controls, head view)
// Parameters: DEPTH (power of two, 2..16), AW (address width).
// -----------------------------------------------------------------------------
module sisc_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_f,
  sisc_fetch_queue_if.master     bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;   // address of the request in flight
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;

  logic [31:0]   word_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q   [DEPTH];

  logic          accept_s;
  logic          pop_s;
  logic          hlt_word_s;
  logic          credit_s;
  logic          issue_s;
  logic [CW:0]   occ_s;

  // Response/pop qualification and request credit
  always_comb begin
    hlt_word_s = (bus.im_rdata[31:28] == 4'hF);
    accept_s   = bus.im_valid & ~drop_q & ~bus.br_taken;
    pop_s      = bus.ir_load & (count_q != {CW{1'b0}}) & ~bus.br_taken;
    occ_s      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    credit_s   = (occ_s < (CW+1)'(DEPTH));
    // The request is suppressed while rst_f is high so the bus is quiet during
    // reset, and in the cycle a HLT word is accepted so nothing is fetched
    // past the HLT address.
    issue_s    = ~rst_f & (state_q == S_RUN) & credit_s & ~bus.br_taken
                 & ~(accept_s & hlt_word_s);
  end

  // Bus and head-of-queue outputs
  always_comb begin
    bus.im_req   = issue_s;
    bus.im_addr  = fetch_pc_q;
    bus.iq_valid = (count_q != {CW{1'b0}});
    bus.halted   = (state_q == S_HALT);
    if (count_q != {CW{1'b0}}) begin
      bus.ir_out  = word_mem_q[rd_ptr_q];
      bus.head_pc = pc_mem_q[rd_ptr_q];
    end else begin
      bus.ir_out  = 32'h0000_0000;
      bus.head_pc = {AW{1'b0}};
    end
    bus.opcode = bus.ir_out[31:28];
    bus.mm     = bus.ir_out[27:24];
  end

  // Next-state: redirect beats push, pop and HLT detection
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = issue_s ? fetch_pc_q : pend_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = issue_s;
    drop_d     = drop_q;
    if (bus.br_taken) begin
      state_d    = S_RUN;
      fetch_pc_d = bus.br_target;
      count_d    = {CW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      // An in-flight response that already arrived this cycle is discarded
      // here; only a response still outstanding needs the drop flag.
      drop_d     = inflight_q & ~bus.im_valid;
    end else begin
      if (bus.im_valid & drop_q) begin
        drop_d = 1'b0;
      end else begin
        drop_d = drop_q;
      end
      if (accept_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (hlt_word_s) begin
          state_d = S_HALT;
        end else begin
          state_d = state_q;
        end
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({accept_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (issue_s) begin
        fetch_pc_d = fetch_pc_q + AW'(1);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q    <= S_RUN;
      fetch_pc_q <= {AW{1'b0}};
      pend_pc_q  <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage; contents are only visible through count, so no reset needed
  always_ff @(posedge clk) begin
    if (!rst_f && accept_s) begin
      word_mem_q[wr_ptr_q] <= bus.im_rdata;
      pc_mem_q[wr_ptr_q]   <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_sisc_fetch_queue.sv
module tb_sisc_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 16;

  logic clk;
  logic rst_f;

  sisc_fetch_queue_if #(.AW(AW)) bus();

  sisc_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected DUT outputs for one cycle
  typedef struct {
    bit          req;
    logic [15:0] addr;
    bit          vld;
    logic [31:0] w;
    logic [15:0] pc;
    bit          hlt;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [15:0] pc;
  } ent_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   n_pushed    = 0;
  int   n_popped    = 0;

  // reference model: queue of fetched entries and fetch bookkeeping
  ent_t        m_q[$];
  int unsigned m_fetch_pc = 0;
  bit          m_pend     = 1'b0;
  logic [15:0] m_pend_addr = 16'h0;
  bit          m_halted   = 1'b0;
  bit          m_drop     = 1'b0;

  // memory responder state
  bit          mem_pend = 1'b0;
  logic [31:0] mem_word = 32'h0;
  int          mode     = 0;
  bit          hlt_en   = 1'b0;
  logic [15:0] hlt_addr = 16'h0;

  function automatic logic [31:0] word_for(input logic [15:0] a);
    logic [31:0] r;
    if (hlt_en && a == hlt_addr) begin
      r = 32'hF000_0000;
    end else if (mode == 0) begin
      r = {16'h0000, a};
    end else begin
      r = $urandom;
      if ($urandom % 32 == 0) r[31:28] = 4'hF;
      else if (r[31:28] == 4'hF) r[31:28] = 4'h1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // one clock: drive inputs, predict outputs, answer requests, advance model
  task automatic step(input bit r, input bit ld, input bit br, input logic [15:0] tgt);
    exp_t e;
    bit   hlt_now;
    @(posedge clk);
    #1;
    rst_f         = r;
    bus.ir_load   = ld;
    bus.br_taken  = br;
    bus.br_target = tgt;
    bus.im_valid  = mem_pend;
    bus.im_rdata  = mem_pend ? mem_word : 32'h0;
    @(negedge clk);
    e.vld = (m_q.size() > 0);
    e.w   = e.vld ? m_q[0].w  : 32'h0;
    e.pc  = e.vld ? m_q[0].pc : 16'h0;
    e.hlt = m_halted;
    hlt_now = !r && !br && bus.im_valid && !m_drop && (bus.im_rdata[31:28] == 4'hF);
    e.req  = !r && !m_halted && !br && !hlt_now && (m_q.size() + int'(m_pend) < DEPTH);
    e.addr = m_fetch_pc[15:0];
    exp_q.push_back(e);
    n_pushed++;
    mem_pend = (bus.im_req === 1'b1);
    mem_word = word_for(bus.im_addr);
    if (r) begin
      m_q.delete();
      m_fetch_pc = 0;
      m_pend     = 1'b0;
      m_halted   = 1'b0;
      m_drop     = 1'b0;
    end else if (br) begin
      m_q.delete();
      m_fetch_pc = {16'h0, tgt};
      m_halted   = 1'b0;
      m_drop     = m_pend && !bus.im_valid;
      m_pend     = 1'b0;
    end else begin
      if (ld && m_q.size() > 0) void'(m_q.pop_front());
      if (bus.im_valid) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          m_q.push_back('{w: bus.im_rdata, pc: m_pend_addr});
          if (bus.im_rdata[31:28] == 4'hF) m_halted = 1'b1;
        end
      end
      if (e.req) begin
        m_pend      = 1'b1;
        m_pend_addr = m_fetch_pc[15:0];
        m_fetch_pc  = (m_fetch_pc + 1) % 65536;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  // monitor: compare whatever the DUT presents against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_popped++;
        chk("im_req", {31'h0, bus.im_req}, {31'h0, e.req});
        if (e.req) chk("im_addr", {16'h0, bus.im_addr}, {16'h0, e.addr});
        chk("iq_valid", {31'h0, bus.iq_valid}, {31'h0, e.vld});
        chk("ir_out", bus.ir_out, e.w);
        chk("opcode", {28'h0, bus.opcode}, {28'h0, e.w[31:28]});
        chk("mm", {28'h0, bus.mm}, {28'h0, e.w[27:24]});
        chk("head_pc", {16'h0, bus.head_pc}, {16'h0, e.pc});
        chk("halted", {31'h0, bus.halted}, {31'h0, e.hlt});
      end
    end
  end

  initial begin
    rst_f         = 1'b1;
    bus.ir_load   = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 16'h0;
    bus.im_valid  = 1'b0;
    bus.im_rdata  = 32'h0;

    // reset, then fill with no consumption: requests 0..3 then stall
    repeat (2) step(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (8) step(1'b0, 1'b0, 1'b0, 16'h0);
    // continuous consumption: one word per cycle
    repeat (16) step(1'b0, 1'b1, 1'b0, 16'h0);

    // redirect with 3 queued and one in flight, same-cycle ir_load/im_valid
    step(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0040);
    repeat (10) step(1'b0, 1'b1, 1'b0, 16'h0);

    // consume while empty
    step(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 16'h0);

    // HLT at address 5, drain, then resume via redirect
    hlt_en   = 1'b1;
    hlt_addr = 16'h0005;
    step(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (6)  step(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (14) step(1'b0, 1'b1, 1'b0, 16'h0);
    hlt_en = 1'b0;
    step(1'b0, 1'b1, 1'b1, 16'h0010);
    repeat (8) step(1'b0, 1'b1, 1'b0, 16'h0);

    // fetch address wrap
    step(1'b0, 1'b1, 1'b1, 16'hFFFF);
    repeat (6) step(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 16'h0);

    // randomized traffic
    mode = 1;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 100) == 0, ($urandom % 10) < 7, ($urandom % 100) < 4,
           16'($urandom_range(0, 65535)));
    end

    #5;
    chk("scoreboard_drain", n_popped, n_pushed);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
